// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative multiply/divide unit for the execute stage. Owns the HI/LO
// registers and computes one bit per cycle: shift-add for multiplies and
// restoring shift-subtract for divides. Operands are latched as magnitudes.
// Sign correction happens in a final FIX cycle that also writes HI/LO.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   rs_data, rt_data       operand A (multiplicand/dividend), operand B
//   mult/multu/div/divu    start strobes (priority mult > multu > div > divu)
//   mfhi/mflo              combinational HI/LO read onto rd_data/rd_we
//   mthi/mtlo              write rs_data into HI/LO when not busy
//   rd_data, rd_we         register-file write path for mfhi/mflo
//   busy, stall            operation in flight / pipeline hold request
//   done, div_by_zero      one-cycle completion pulse and divide-by-zero flag
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mult,
  input  logic             multu,
  input  logic             div,
  input  logic             divu,
  input  logic             mfhi,
  input  logic             mflo,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_we,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Working register: multiply  = {partial high, multiplier shifting out}
  //                   divide    = {remainder,    dividend -> quotient}
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;  // raw dividend for the divide-by-zero result
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;  // negate product / quotient
  logic               neg_hi_q, neg_hi_d;  // negate remainder
  logic               bzero_q, bzero_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Start decode with priority
  logic             start_any;
  logic             op_sgn;
  logic             op_div;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  always_comb begin
    start_any = mult | multu | div | divu;
    op_sgn    = 1'b0;
    op_div    = 1'b1;
    if (mult) begin
      op_sgn = 1'b1;
      op_div = 1'b0;
    end else if (multu) begin
      op_sgn = 1'b0;
      op_div = 1'b0;
    end else if (div) begin
      op_sgn = 1'b1;
      op_div = 1'b1;
    end
    // 0x80000000 maps to itself, which is the correct unsigned magnitude
    rs_mag = (op_sgn && rs_data[WIDTH-1]) ? (~rs_data + 1'b1) : rs_data;
    rt_mag = (op_sgn && rt_data[WIDTH-1]) ? (~rt_data + 1'b1) : rt_data;
  end

  // One iteration of each algorithm
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    // Bit WIDTH of the difference is the borrow: set means restore
    div_diff = div_sh - {1'b0, opnd_q};
    prod_fix = neg_lo_q ? (~p_q + 1'b1) : p_q;
    quo_fix  = neg_lo_q ? (~p_q[WIDTH-1:0] + 1'b1) : p_q[WIDTH-1:0];
    rem_fix  = neg_hi_q ? (~p_q[2*WIDTH-1:WIDTH] + 1'b1) : p_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    bzero_d  = bzero_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mthi) hi_d = rs_data;
        if (mtlo) lo_d = rs_data;
        if (start_any) begin
          state_d  = RUN;
          cnt_d    = CW'(WIDTH - 1);
          is_div_d = op_div;
          bzero_d  = (rt_data == '0);
          a_raw_d  = rs_data;
          neg_lo_d = op_sgn & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          if (op_div) begin
            opnd_d   = rt_mag;
            p_d      = {{WIDTH{1'b0}}, rs_mag};
            neg_hi_d = op_sgn & rs_data[WIDTH-1];
          end else begin
            opnd_d   = rs_mag;
            p_d      = {{WIDTH{1'b0}}, rt_mag};
            neg_hi_d = 1'b0;
          end
        end
      end

      RUN: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
          else                  p_d = {div_sh[WIDTH-1:0],   p_q[WIDTH-2:0], 1'b0};
        end else begin
          p_d = {mul_sum, p_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end

      FIX: begin
        if (is_div_q) begin
          if (bzero_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          dbz_d = bzero_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      bzero_q  <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      bzero_q  <= bzero_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  // Outputs. FIX still counts as busy, so HI/LO are stable whenever reads are granted.
  always_comb begin
    busy        = (state_q != IDLE);
    stall       = busy & (mfhi | mflo | mthi | mtlo);
    rd_we       = ~busy & (mfhi | mflo);
    rd_data     = '0;
    if (!busy) begin
      if (mfhi)      rd_data = hi_q;
      else if (mflo) rd_data = lo_q;
    end
    done        = done_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit. A scoreboard queue holds the expected
// HI/LO/flag of every accepted operation. Entries are popped and compared
// in the done cycle, when HI/LO are read back through mfhi/mflo.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  rs_data, rt_data;
  logic          mult, multu, div, divu;
  logic          mfhi, mflo, mthi, mtlo;
  logic [W-1:0]  rd_data;
  logic          rd_we, busy, stall, done, div_by_zero;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .rs_data(rs_data), .rt_data(rt_data),
    .mult(mult), .multu(multu), .div(div), .divu(divu),
    .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
    .rd_data(rd_data), .rd_we(rd_we),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: wide arithmetic, priority applied to the strobe vector {mult,multu,div,divu}
  function automatic exp_t model(input logic [3:0] strb, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dbz = 1'b0;
    if (strb[3]) begin
      p = 64'(sa * sb);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (strb[2]) begin
      p = {32'b0, a} * {32'b0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else if (strb[1]) begin
      q = sa / sb;
      r = sa % sb;
      e.hi = 32'(r);
      e.lo = 32'(q);
    end else begin
      e.hi = a % b;
      e.lo = a / b;
    end
    return e;
  endfunction

  // Drive one start strobe for a cycle. Operands are scrambled right after acceptance.
  task automatic start_op(input logic [3:0] strb, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input bit with_mthi);
    @(posedge clk); #1;
    rs_data = a;
    rt_data = b;
    {mult, multu, div, divu} = strb;
    mthi = with_mthi;
    if (push) sb_q.push_back(model(strb, a, b));
    @(posedge clk); #1;
    {mult, multu, div, divu} = 4'b0000;
    mthi    = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    #1;
    check_val("busy_after_start", busy, 1);
  endtask

  // Wait for done, check latency and busy width, then compare the scoreboard entry
  task automatic wait_done(input string tag);
    int   cyc;
    int   busy_cyc;
    bit   seen;
    exp_t e;
    cyc = 0; busy_cyc = 1; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk); #2;
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) busy_cyc++;
    end
    check_val({tag, "_done_seen"}, seen, 1);
    if (!seen) return;
    check_val({tag, "_latency"}, cyc, 33);
    check_val({tag, "_busy_cycles"}, busy_cyc, 33);
    check_val({tag, "_busy_in_done"}, busy, 0);
    check_val({tag, "_sb_nonempty"}, sb_q.size() != 0, 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check_val({tag, "_dbz"}, div_by_zero, e.dbz);
    mfhi = 1'b1; #1;
    check_val({tag, "_hi"}, rd_data, e.hi);
    check_val({tag, "_hi_we"}, rd_we, 1);
    mfhi = 1'b0; mflo = 1'b1; #1;
    check_val({tag, "_lo"}, rd_data, e.lo);
    mflo = 1'b0;
    $display("txn %s: hi=0x%08h lo=0x%08h dbz=%0d latency=%0d", tag, e.hi, e.lo, e.dbz, cyc);
    @(posedge clk); #2;
    check_val({tag, "_done_one_cycle"}, done, 0);
    check_val({tag, "_dbz_one_cycle"}, div_by_zero, 0);
  endtask

  // mflo held from cycle 5 and a mult strobe mid-operation with new operands
  task automatic hazard_op();
    int   cyc;
    bit   seen;
    exp_t e;
    start_op(4'b1000, 32'h0001_2345, 32'hFFFF_F000, 1, 0);
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) mflo = 1'b1;
      if (cyc == 8) begin rs_data = 32'h7; rt_data = 32'h9; mult = 1'b1; end
      if (cyc == 9) mult = 1'b0;
      #1;
      if (done) seen = 1'b1;
      else if (mflo) begin
        check_val("hz_stall", stall, 1);
        check_val("hz_rd_we_held", rd_we, 0);
        check_val("hz_rd_data_held", rd_data, 0);
      end
    end
    check_val("hz_done_seen", seen, 1);
    check_val("hz_sb_nonempty", sb_q.size() != 0, 1);
    if (seen && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val("hz_stall_done", stall, 0);
      check_val("hz_rd_we_done", rd_we, 1);
      check_val("hz_lo", rd_data, e.lo);
      mflo = 1'b0; mfhi = 1'b1; #1;
      check_val("hz_hi", rd_data, e.hi);
      mfhi = 1'b0;
      $display("txn hazard: hi=0x%08h lo=0x%08h", e.hi, e.lo);
    end
    mflo = 1'b0;
    @(posedge clk); #2;
    check_val("hz_no_restart", busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dn_seen;
    rst = 1'b1;
    rs_data = '0; rt_data = '0;
    {mult, multu, div, divu} = 4'b0000;
    {mfhi, mflo, mthi, mtlo} = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_dbz", div_by_zero, 0);
    check_val("rst_stall", stall, 0);
    check_val("rst_rd_we", rd_we, 0);
    check_val("rst_rd_data", rd_data, 0);
    mfhi = 1'b1; #1;
    check_val("rst_hi", rd_data, 0);
    check_val("rst_hi_we", rd_we, 1);
    mfhi = 1'b0;
    $display("txn reset: outputs idle, HI=0");

    // mthi then mtlo while idle; mfhi wins over mflo
    @(posedge clk); #1 rs_data = 32'h0000_ABCD; mthi = 1'b1;
    @(posedge clk); #1 mthi = 1'b0; rs_data = 32'h0000_1357; mtlo = 1'b1; mfhi = 1'b1;
    #1 check_val("mthi_read", rd_data, 32'h0000_ABCD);
    @(posedge clk); #1 mtlo = 1'b0; mflo = 1'b1;
    #1 check_val("mfhi_priority", rd_data, 32'h0000_ABCD);
    mfhi = 1'b0;
    #1 check_val("mtlo_read", rd_data, 32'h0000_1357);
    mflo = 1'b0;
    $display("txn mthi/mtlo: HI=0xABCD LO=0x1357");

    // Asynchronous reset in the middle of a multu
    start_op(4'b0100, 32'd7, 32'd6, 0, 0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_val("midrst_busy", busy, 0);
    #1 rst = 1'b0;
    dn_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #2;
      if (done) dn_seen = 1'b1;
    end
    check_val("midrst_no_done", dn_seen, 0);
    check_val("midrst_busy_after", busy, 0);
    mflo = 1'b1; #1;
    check_val("midrst_lo", rd_data, 0);
    check_val("midrst_lo_we", rd_we, 1);
    mflo = 1'b0; mfhi = 1'b1; #1;
    check_val("midrst_hi", rd_data, 0);
    mfhi = 1'b0;
    $display("txn reset mid-run: HI/LO cleared, no done");

    start_op(4'b1000, 32'hFFFF_FFFD, 32'd5, 1, 0);          wait_done("mult_neg3x5");
    start_op(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);  wait_done("multu_max");
    start_op(4'b0010, 32'hFFFF_FFF9, 32'd2, 1, 0);          wait_done("div_neg7by2");
    start_op(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);  wait_done("div_overflow");
    start_op(4'b0001, 32'h0000_1234, 32'd0, 1, 0);          wait_done("divu_by_zero");
    start_op(4'b0010, 32'hFFFF_FF00, 32'd0, 1, 0);          wait_done("div_by_zero");
    start_op(4'b0010, 32'd100, 32'hFFFF_FFF9, 1, 0);        wait_done("div_pos_by_neg");
    start_op(4'b1001, 32'h10, 32'd3, 1, 0);                 wait_done("prio_mult_divu");
    start_op(4'b0011, 32'hFFFF_FFF0, 32'd3, 1, 0);          wait_done("prio_div_divu");
    start_op(4'b0001, 32'h1234_5678, 32'h55, 1, 1);         wait_done("mthi_with_start");

    hazard_op();

    for (int i = 0; i < 8; i++) begin
      logic [3:0]  s;
      logic [31:0] a, b;
      s = 4'b1000 >> (i % 4);
      a = $urandom;
      b = (i == 6) ? 32'd0 : ((i % 4 >= 2) ? ($urandom >> (i * 3)) : $urandom);
      start_op(s, a, b, 1, 0);
      wait_done($sformatf("rand%0d", i));
    end

    check_val("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
